// File: rtl/fib_lpm.sv
// fib_lpm: hash-indexed FIB with one valid bit per (length, hash) slot,
// serving insert, delete, longest-prefix-match lookup and clear.
module fib_lpm #(
    parameter int PREFIX_W = 64,
    parameter int LEN_W    = 6,
    parameter int HASH_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [PREFIX_W-1:0]       cmd_prefix,
    input  logic [LEN_W-1:0]          cmd_len,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_hit,
    output logic [LEN_W-1:0]          resp_len,
    output logic [PREFIX_W-1:0]       resp_prefix,
    output logic [LEN_W+HASH_W:0]     entry_count
);
    localparam int ROWS = 2 ** LEN_W;
    localparam int NCH  = (PREFIX_W + HASH_W - 1) / HASH_W;

    typedef enum logic [2:0] {INIT, IDLE, HASH, PROBE, CLEAR, RESP} state_t;
    state_t state, state_nx;

    logic [1:0]              op;
    logic [PREFIX_W-1:0]     prefix;
    logic [LEN_W-1:0]        cur_len;
    logic [HASH_W-1:0]       h;
    logic [HASH_W-1:0]       h_nx;
    logic [LEN_W:0]          row;
    logic [PREFIX_W-1:0]     masked;
    logic [NCH*HASH_W-1:0]   padded;
    logic [2**HASH_W-1:0]    mem [ROWS];
    logic                    slot;
    logic                    accept;

    assign cmd_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign accept     = cmd_valid && cmd_ready;
    assign slot       = mem[cur_len][h];

    always_comb begin
        masked = prefix & ~({PREFIX_W{1'b1}} << cur_len);
        padded = (NCH*HASH_W)'(masked);
        h_nx   = HASH_W'(cur_len);
        for (int i = 0; i < NCH; i++) h_nx ^= padded[i*HASH_W +: HASH_W];
    end

    // A len==0 command passes through HASH to keep its one-cycle response slot but never probes.
    always_comb begin
        state_nx = state;
        case (state)
            INIT:    state_nx = CLEAR;
            IDLE:    state_nx = !accept ? IDLE : cmd_op == 2'd3 ? CLEAR : HASH;
            HASH:    state_nx = cur_len == '0 ? RESP : PROBE;
            PROBE:   state_nx = (op == 2'd0 && !slot && cur_len != 1) ? HASH : RESP;
            CLEAR:   state_nx = !row[LEN_W] ? CLEAR : op == 2'd3 ? RESP : IDLE;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            op          <= '0;
            prefix      <= '0;
            cur_len     <= '0;
            h           <= '0;
            row         <= '0;
            resp_hit    <= 1'b0;
            resp_len    <= '0;
            resp_prefix <= '0;
            entry_count <= '0;
        end else begin
            state <= state_nx;
            row   <= state == CLEAR ? row + 1'b1 : '0;
            if (accept) begin
                op          <= cmd_op;
                prefix      <= cmd_prefix;
                cur_len     <= cmd_len;
                resp_hit    <= 1'b0;
                resp_len    <= '0;
                resp_prefix <= cmd_prefix;
            end
            if (state == HASH) h <= h_nx;
            if (state == CLEAR && row[LEN_W]) entry_count <= '0;
            if (state == PROBE) begin
                if (op == 2'd1 && !slot) entry_count <= entry_count + 1'b1;
                if (op == 2'd2 && slot) entry_count <= entry_count - 1'b1;
                if (slot) begin
                    resp_hit    <= 1'b1;
                    resp_len    <= cur_len;
                    resp_prefix <= masked;
                end else if (op == 2'd0 && cur_len != 1) begin
                    cur_len <= cur_len - 1'b1;
                end
            end
        end
    end

    // Storage holds no reset; the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (state == CLEAR && !row[LEN_W]) mem[row[LEN_W-1:0]] <= '0;
        else if (state == PROBE && op == 2'd1) mem[cur_len][h] <= 1'b1;
        else if (state == PROBE && op == 2'd2) mem[cur_len][h] <= 1'b0;
    end
endmodule

// File: tb/tb_fib_lpm.sv
// tb_fib_lpm: vector table, backpressure/reset sequences and randomized ops
// against a set-based FIB model.
module tb_fib_lpm;
    logic        clk = 0;
    logic        rst = 1;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 0;
    logic [63:0] cmd_prefix = 0;
    logic [5:0]  cmd_len = 0;
    logic        resp_valid;
    logic        resp_ready = 0;
    logic        resp_hit;
    logic [5:0]  resp_len;
    logic [63:0] resp_prefix;
    logic [16:0] entry_count;

    int tests = 0;
    int fails = 0;
    bit mv [int];

    fib_lpm dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_prefix(cmd_prefix), .cmd_len(cmd_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_len(resp_len), .resp_prefix(resp_prefix), .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [63:0] p;
        logic [5:0]  l;
        logic        hit;
        logic [5:0]  rl;
        logic [63:0] rp;
        int          lat;
        int          cnt;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] href(input logic [63:0] p, input int l);
        logic [9:0] hv = 10'(l);
        for (int i = 0; i < l; i++) hv[i % 10] ^= p[i];
        return hv;
    endfunction

    function automatic logic [63:0] msk(input logic [63:0] p, input int l);
        return p & ((64'd1 << l) - 64'd1);
    endfunction

    function automatic int key(input logic [63:0] p, input int l);
        return l * 1024 + int'(href(p, l));
    endfunction

    task automatic send(input logic [1:0] op, input logic [63:0] p, input logic [5:0] l,
                        output logic hit, output logic [5:0] rl, output logic [63:0] rp,
                        output int lat, output int cnt);
        int n = 0;
        while (!cmd_ready && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1; cmd_op = op; cmd_prefix = p; cmd_len = l;
        @(posedge clk); #1;
        cmd_valid = 0;
        lat = 0;
        while (!resp_valid && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
        hit = resp_hit; rl = resp_len; rp = resp_prefix; cnt = int'(entry_count);
    endtask

    task automatic finish_resp();
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
    endtask

    task automatic do_reset();
        int early = 0;
        rst = 1; cmd_valid = 0; resp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_hit", 64'(resp_hit), 64'd0);
        check("rst_resp_len", 64'(resp_len), 64'd0);
        check("rst_resp_prefix", resp_prefix, 64'd0);
        check("rst_entry_count", 64'(entry_count), 64'd0);
        rst = 0;
        for (int e = 1; e <= 65; e++) begin
            @(posedge clk); #1;
            if (cmd_ready) early++;
        end
        check("init_ready_low_cycles", 64'(early), 64'd0);
        @(posedge clk); #1;
        check("init_ready_high", 64'(cmd_ready), 64'd1);
        mv.delete();
    endtask

    initial begin
        logic        hit;
        logic [5:0]  rl;
        logic [63:0] rp;
        int          lat, cnt;
        logic [63:0] pool [4];

        vt[0]  = '{2'd0, 64'h1_2345_6789, 6'd63, 1'b0, 6'd0,  64'h1_2345_6789, 126, 0};
        vt[1]  = '{2'd1, 64'hABCD,        6'd16, 1'b0, 6'd0,  64'hABCD,        2,   1};
        vt[2]  = '{2'd1, 64'hABCD,        6'd16, 1'b1, 6'd16, 64'hABCD,        2,   1};
        vt[3]  = '{2'd0, 64'h12ABCD,      6'd24, 1'b1, 6'd16, 64'hABCD,        18,  1};
        vt[4]  = '{2'd1, 64'hFF00CD,      6'd8,  1'b0, 6'd0,  64'hFF00CD,      2,   2};
        vt[5]  = '{2'd0, 64'hABCD,        6'd20, 1'b1, 6'd16, 64'hABCD,        10,  2};
        vt[6]  = '{2'd2, 64'hABCD,        6'd16, 1'b1, 6'd16, 64'hABCD,        2,   1};
        vt[7]  = '{2'd0, 64'hABCD,        6'd20, 1'b1, 6'd8,  64'hCD,          26,  1};
        vt[8]  = '{2'd0, 64'hFFFF,        6'd0,  1'b0, 6'd0,  64'hFFFF,        1,   1};
        vt[9]  = '{2'd1, 64'h7,           6'd0,  1'b0, 6'd0,  64'h7,           1,   1};
        vt[10] = '{2'd2, 64'h1234,        6'd12, 1'b0, 6'd0,  64'h1234,        2,   1};
        vt[11] = '{2'd1, 64'h1,           6'd1,  1'b0, 6'd0,  64'h1,           2,   2};
        vt[12] = '{2'd1, 64'h3,           6'd2,  1'b0, 6'd0,  64'h3,           2,   3};
        vt[13] = '{2'd3, 64'h55,          6'd5,  1'b0, 6'd0,  64'h55,          65,  0};
        vt[14] = '{2'd0, 64'hCD,          6'd8,  1'b0, 6'd0,  64'hCD,          16,  0};
        vt[15] = '{2'd0, 64'hABCD,        6'd16, 1'b0, 6'd0,  64'hABCD,        32,  0};

        do_reset();

        for (int i = 0; i < 16; i++) begin
            send(vt[i].op, vt[i].p, vt[i].l, hit, rl, rp, lat, cnt);
            check($sformatf("v%0d_hit", i), 64'(hit), 64'(vt[i].hit));
            check($sformatf("v%0d_len", i), 64'(rl), 64'(vt[i].rl));
            check($sformatf("v%0d_prefix", i), rp, vt[i].rp);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].lat));
            check($sformatf("v%0d_count", i), 64'(cnt), 64'(vt[i].cnt));
            finish_resp();
        end

        send(2'd0, 64'h5, 6'd3, hit, rl, rp, lat, cnt);
        check("bp_latency", 64'(lat), 64'd6);
        cmd_valid = 1; cmd_op = 2'd1; cmd_prefix = 64'h5; cmd_len = 6'd3;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_hit", 64'(resp_hit), 64'd0);
            check("bp_len", 64'(resp_len), 64'd0);
            check("bp_prefix", resp_prefix, 64'h5);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        cmd_valid = 0;
        finish_resp();
        check("bp_ready_after_handshake", 64'(cmd_ready), 64'd1);
        check("bp_count_unchanged", 64'(entry_count), 64'd0);

        for (int k = 0; k < 4; k++) pool[k] = {$urandom, $urandom};
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  op;
            logic [63:0] p;
            int          l, r, e_lat, e_len;
            logic        e_hit, found;
            logic [63:0] e_pfx;
            r  = $urandom_range(0, 9);
            op = r < 4 ? 2'd1 : r < 6 ? 2'd2 : 2'd0;
            p  = pool[$urandom_range(0, 3)] ^ ({$urandom, $urandom} << 24);
            l  = op == 2'd0 ? $urandom_range(0, 16) : $urandom_range(0, 12);
            e_hit = 0; e_len = 0; e_pfx = p; found = 0;
            if (l == 0) e_lat = 1;
            else if (op == 2'd0) begin
                e_lat = 2 * l;
                for (int k = l; k >= 1; k--) begin
                    if (!found && mv.exists(key(p, k))) begin
                        found = 1; e_hit = 1; e_len = k; e_pfx = msk(p, k); e_lat = 2 * (l - k + 1);
                    end
                end
            end else begin
                e_lat = 2;
                if (mv.exists(key(p, l))) begin
                    e_hit = 1; e_len = l; e_pfx = msk(p, l);
                end
                if (op == 2'd1) mv[key(p, l)] = 1;
                else mv.delete(key(p, l));
            end
            send(op, p, 6'(l), hit, rl, rp, lat, cnt);
            check($sformatf("r%0d_hit", n), 64'(hit), 64'(e_hit));
            check($sformatf("r%0d_len", n), 64'(rl), 64'(e_len));
            check($sformatf("r%0d_prefix", n), rp, e_pfx);
            check($sformatf("r%0d_latency", n), 64'(lat), 64'(e_lat));
            check($sformatf("r%0d_count", n), 64'(cnt), 64'(mv.num()));
            finish_resp();
        end

        send(2'd1, 64'h9, 6'd2, hit, rl, rp, lat, cnt);
        finish_resp();
        send(2'd0, 64'h9, 6'd2, hit, rl, rp, lat, cnt);
        check("mid_lookup_hit", 64'(hit), 64'd1);
        check("mid_lookup_latency", 64'(lat), 64'd2);
        rst = 1;
        #1;
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("mid_rst_count", 64'(entry_count), 64'd0);
        do_reset();
        send(2'd0, 64'h9, 6'd2, hit, rl, rp, lat, cnt);
        check("post_rst_hit", 64'(hit), 64'd0);
        check("post_rst_latency", 64'(lat), 64'd4);
        check("post_rst_prefix", rp, 64'h9);
        finish_resp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
